// File: rtl/alu_issue_pkg.sv
// ALU opcode, decoded-control and pre-shift types shared by the issue stage and the ALU.
// Pure type/constant definitions; no logic.
package p_alu;

    localparam int ALU_OPCODE_W = 5;

    typedef enum logic [ALU_OPCODE_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_RSB  = 5'd2,
        ALU_AND  = 5'd3,
        ALU_OR   = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_BIC  = 5'd6,
        ALU_NAND = 5'd7,
        ALU_SHL  = 5'd8,
        ALU_SHR  = 5'd9,
        ALU_ASL  = 5'd10,
        ALU_ASR  = 5'd11,
        ALU_ROL  = 5'd12,
        ALU_ROR  = 5'd13,
        ALU_MOV  = 5'd14,
        ALU_NEG  = 5'd15
    } e_alu_opcode;

    typedef enum logic [3:0] {
        CORE_OP_ADD     = 4'd0,
        CORE_OP_AND     = 4'd1,
        CORE_OP_XOR     = 4'd2,
        CORE_OP_SHL     = 4'd3,
        CORE_OP_SHR     = 4'd4,
        CORE_OP_ASL     = 4'd5,
        CORE_OP_ASR     = 4'd6,
        CORE_OP_ROL     = 4'd7,
        CORE_OP_ROR     = 4'd8,
        CORE_OP_INVALID = 4'd9
    } e_core_op;

    typedef enum logic [1:0] {
        UNARY_ID   = 2'd0,
        UNARY_NEG  = 2'd1,
        UNARY_NOT  = 2'd2,
        UNARY_ZERO = 2'd3
    } e_unary_op;

    typedef struct packed {
        logic       en;
        logic [1:0] kind;
        logic [4:0] amount;
    } s_shift;

    // Opcode-derived part of the control word; pre_shift is supplied separately.
    typedef struct packed {
        e_core_op  core;
        e_unary_op a_op;
        e_unary_op b_op;
        e_unary_op out_op;
    } s_decode;

    typedef struct packed {
        s_shift    pre_shift;
        e_core_op  core;
        e_unary_op a_op;
        e_unary_op b_op;
        e_unary_op out_op;
    } s_control;

endpackage

// File: rtl/alu_issue_op_decode.sv
// Combinational opcode -> core/unary-op decode with illegal flag; zero latency, no handshake.
module alu_op_decode
    import p_alu::*;
(
    input  logic [ALU_OPCODE_W-1:0] i_opcode,
    output s_decode                 o_dec,
    output logic                    o_illegal
);

    always_comb begin
        o_dec     = '{core: CORE_OP_INVALID, a_op: UNARY_ID, b_op: UNARY_ID, out_op: UNARY_ID};
        o_illegal = 1'b0;
        case (e_alu_opcode'(i_opcode))
            ALU_ADD:  o_dec = '{CORE_OP_ADD, UNARY_ID,  UNARY_ID,   UNARY_ID};
            ALU_SUB:  o_dec = '{CORE_OP_ADD, UNARY_ID,  UNARY_NEG,  UNARY_ID};
            ALU_RSB:  o_dec = '{CORE_OP_ADD, UNARY_NEG, UNARY_ID,   UNARY_ID};
            ALU_AND:  o_dec = '{CORE_OP_AND, UNARY_ID,  UNARY_ID,   UNARY_ID};
            // OR via De Morgan on the AND core
            ALU_OR:   o_dec = '{CORE_OP_AND, UNARY_NOT, UNARY_NOT,  UNARY_NOT};
            ALU_XOR:  o_dec = '{CORE_OP_XOR, UNARY_ID,  UNARY_ID,   UNARY_ID};
            ALU_BIC:  o_dec = '{CORE_OP_AND, UNARY_ID,  UNARY_NOT,  UNARY_ID};
            ALU_NAND: o_dec = '{CORE_OP_AND, UNARY_ID,  UNARY_ID,   UNARY_NOT};
            ALU_SHL:  o_dec = '{CORE_OP_SHL, UNARY_ID,  UNARY_ID,   UNARY_ID};
            ALU_SHR:  o_dec = '{CORE_OP_SHR, UNARY_ID,  UNARY_ID,   UNARY_ID};
            ALU_ASL:  o_dec = '{CORE_OP_ASL, UNARY_ID,  UNARY_ID,   UNARY_ID};
            ALU_ASR:  o_dec = '{CORE_OP_ASR, UNARY_ID,  UNARY_ID,   UNARY_ID};
            ALU_ROL:  o_dec = '{CORE_OP_ROL, UNARY_ID,  UNARY_ID,   UNARY_ID};
            ALU_ROR:  o_dec = '{CORE_OP_ROR, UNARY_ID,  UNARY_ID,   UNARY_ID};
            ALU_MOV:  o_dec = '{CORE_OP_ADD, UNARY_ID,  UNARY_ZERO, UNARY_ID};
            ALU_NEG:  o_dec = '{CORE_OP_ADD, UNARY_NEG, UNARY_ZERO, UNARY_ID};
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode + two-entry skid buffer, 1-cycle latency, full throughput.
// Backpressure: o_ready drops only when both entries are held; it never depends on i_ready.
module alu_issue
    import p_alu::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [ALU_OPCODE_W-1:0] i_opcode,
    input  logic [WIDTH-1:0]        i_a,
    input  logic [WIDTH-1:0]        i_b,
    input  s_shift                  i_pre_shift,
    output logic                    o_valid,
    input  logic                    i_ready,
    output s_control                o_ctrl,
    output logic [WIDTH-1:0]        o_a,
    output logic [WIDTH-1:0]        o_b,
    output logic                    o_illegal,
    output logic [CNT_W-1:0]        o_illegal_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } e_state;

    typedef struct packed {
        s_control          ctrl;
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic              illegal;
    } s_entry;

    e_state           state_q,  state_d;
    s_entry           main_q,   main_d;
    s_entry           skid_q,   skid_d;
    logic             valid_q,  valid_d;
    logic             ready_q,  ready_d;
    logic [CNT_W-1:0] count_q,  count_d;

    s_decode dec;
    logic    dec_illegal;
    s_entry  in_entry;
    logic    accept;
    logic    emit;

    alu_op_decode u_decode (
        .i_opcode  (i_opcode),
        .o_dec     (dec),
        .o_illegal (dec_illegal)
    );

    always_comb begin
        in_entry = '{
            ctrl:    '{pre_shift: i_pre_shift, core: dec.core, a_op: dec.a_op,
                       b_op: dec.b_op, out_op: dec.out_op},
            a:       i_a,
            b:       i_b,
            illegal: dec_illegal
        };

        accept  = i_valid && ready_q;
        emit    = valid_q && i_ready;

        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = count_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    main_d = in_entry;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = ST_FULL;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush overrides everything; the entry offered this cycle is dropped uncounted.
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else if (accept && dec_illegal && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end

        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            count_q <= count_d;
        end
    end

    assign o_valid         = valid_q;
    assign o_ready         = ready_q;
    assign o_ctrl          = main_q.ctrl;
    assign o_a             = main_q.a;
    assign o_b             = main_q.b;
    assign o_illegal       = main_q.illegal;
    assign o_illegal_count = count_q;

endmodule
